muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the multi-cycle HI/LO arithmetic of the execute stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  from execute and runs an iterative shift-add multiplier or restoring divider. Owns the HI/LO registers and
//  drives the pipeline stall while an operation is in flight.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; even, >=4
//  CNT_W  6   iteration counter width; must hold WIDTH-1
// PORTS
//  clk      in   1      clock, rising edge
//  rstn     in   1      reset; asynchronous, active-low
//  start    in   1      op valid from execute; sampled only in IDLE
//  op       in   3      MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO (defines.vh)
//  src_a    in   WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
//  src_b    in   WIDTH  rt operand (divisor / multiplier)
//  flush    in   1      abort in-flight op (exception/branch kill)
//  stall    out  1      combinational; hold execute/upstream stages
//  done     out  1      1-cycle pulse; HI/LO updated by a mul/div
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, hi=lo=0, done=0, stall=0, internal operand/accumulator regs=0.
//    Reset mid-operation abandons the op with no HI/LO write.
//  - FSM states: IDLE, MUL, DIV, DONE.
//    IDLE--start&MULT/MULTU-->MUL.  IDLE--start&DIV/DIVU-->DIV.
//    MUL/DIV--cnt==WIDTH-1-->DONE.  DONE-->IDLE unconditionally.
//  - stall = (IDLE & start & op is mul/div) | MUL | DIV. No stall in DONE, for MTHI/MTLO, or when start=0.
//  - Accept edge E0: latch |src_a|,|src_b| for signed ops (unsigned pass-through); latch result signs; cnt=0.
//  - Iteration edges E1..E32: one bit per cycle; cnt increments.
//    MUL: 2*WIDTH shift-add product.  DIV: one restoring step.
//    On E32 (cnt==WIDTH-1): sign-corrected result written to HI/LO; state -> DONE.
//  - Timing: stall high 33 cycles (WIDTH+1); done high for the DONE cycle, E32..E33.
//  - Results:
//    MULT/MULTU: {hi,lo}=64-bit product.  DIV/DIVU: lo=quotient, hi=remainder.
//    Signed quotient negative iff operand signs differ; remainder takes dividend sign.
//    0x80000000 / -1 -> lo=0x80000000, hi=0 (modulo-2^WIDTH wrap; no trap).
//    Divide by zero (both signednesses): lo=all-ones, hi=src_a unchanged; full latency, no early exit.
//  - MTHI/MTLO in IDLE: written at the next edge; zero latency; no done pulse; the other register is untouched.
//  - start in MUL/DIV/DONE is ignored; execute is stalled, so this is a protocol violation and a bench assertion.
//  - flush:
//    in MUL/DIV: -> IDLE next edge; HI/LO unchanged; no done; stall drops combinationally that cycle.
//    in IDLE: blocks acceptance; includes MTHI/MTLO.  in DONE: no effect, HI/LO already written.
//  - flush & start in the same IDLE cycle: flush wins.
// CONFIGURATION
//  MULDIV_FAST_MULT_EN defined:
//    MULT/MULTU use a single-cycle combinational multiplier.
//    {hi,lo} written at E0; done pulses the following cycle; stall never asserted for multiply; MUL state unused.
//  MULDIV_FAST_MULT_EN undefined:
//    iterative multiply as above, WIDTH+1 stall cycles. Divide is identical in both builds.
// STRUCTURE
//  - defines.vh: MD_* op encodings and FSM state encodings (shared with decode/execute).
//  - Sub-module div_restore_step: combinational single restoring-division step.
//    In: partial remainder, divisor, next dividend bit.  Out: new remainder, quotient bit.
//    The multiply add-shift stays inline.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall 33 cycles; hi=0xFFFFFFFE lo=0x00000001; done 1 pulse.
//    With FAST_MULT: same values, no stall.
//  2 DIV a=-7 (0xFFFFFFF9) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    DIVU a=100 b=7 -> lo=14, hi=2.
//  3 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
//    DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x1234.
//  4 Start DIV, assert flush at iteration 10 -> IDLE next cycle; stall=0; done never; HI/LO keep prior values.
//  5 rstn low at iteration 20 of MULT -> hi=lo=0, stall=0 immediately.
//    Then MTHI 0xA5A5A5A5 -> hi updated next edge, lo=0, stall never high.
//  6 MTLO 0x55 same cycle as flush -> lo unchanged.
//    Back-to-back DIVU then MULTU (start held after DONE) -> second op accepted in IDLE cycle; both results correct.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared op and FSM encodings for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_mul(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> muldiv sequencer handshake; execute is the master.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
    import muldiv_ctrl_pkg::*;

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, src_a, src_b, flush,
                    input  stall, done, hi, lo);
    modport slave  (input  start, op, src_a, src_b, flush,
                    output stall, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl_div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_qbit  = (w_shift >= {1'b0, i_divisor});
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: iterative shift-add multiply, restoring divide, stall control.
// Build option: MULDIV_FAST_MULT_EN selects a single-cycle combinational multiplier.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rstn,
    muldiv_ctrl_if.slave bus
);
    md_state_e          r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opa, r_opb, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q, r_neg_r;

    logic               w_signed, w_a_neg, w_b_neg, w_last, w_go;
    logic               w_stall, w_done;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next, w_prod_fix;
    logic [WIDTH-1:0]   w_div_rem, w_quo, w_quo_fix, w_rem_fix;
    logic               w_div_q;

    assign w_signed = is_signed_op(bus.op);
    assign w_a_neg  = w_signed & bus.src_a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.src_b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_abs_b  = w_b_neg ? -bus.src_b : bus.src_b;
    assign w_last   = (r_cnt == CNT_W'(WIDTH-1));
    assign w_go     = (r_state == ST_IDLE) & bus.start & ~bus.flush;

    // Multiplier lives in the low half of r_acc and shifts out as product bits shift in.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opa : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod_fix = r_neg_q ? -w_mul_next : w_mul_next;

    // r_acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_divisor (r_opb),
        .i_bit     (r_acc[WIDTH-1]),
        .o_rem     (w_div_rem),
        .o_qbit    (w_div_q)
    );
    assign w_quo     = {r_acc[WIDTH-2:0], w_div_q};
    assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
    assign w_rem_fix = r_neg_r ? -w_div_rem : w_div_rem;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{w_a_neg}}, bus.src_a} * {{WIDTH{w_b_neg}}, bus.src_b};
    localparam logic FAST_MUL = 1'b1;
`else
    localparam logic FAST_MUL = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = bus.start & (is_div(bus.op) | (~FAST_MUL & is_mul(bus.op)));
                if (w_go && is_mul(bus.op)) w_next = FAST_MUL ? ST_DONE : ST_MUL;
                if (w_go && is_div(bus.op)) w_next = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                w_stall = ~bus.flush;
                if (bus.flush)   w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_go) begin
                    case (bus.op)
                        MD_MTHI: r_hi <= bus.src_a;
                        MD_MTLO: r_lo <= bus.src_a;
                        MD_MULT, MD_MULTU: begin
                            r_opa   <= w_abs_a;
                            r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_cnt   <= '0;
`ifdef MULDIV_FAST_MULT_EN
                            {r_hi, r_lo} <= w_fast_prod;
`endif
                        end
                        MD_DIV, MD_DIVU: begin
                            r_opb   <= w_abs_b;
                            r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                            // Divide by zero keeps the all-ones quotient unsigned.
                            r_neg_q <= (w_a_neg ^ w_b_neg) & (|bus.src_b);
                            r_neg_r <= w_a_neg;
                            r_cnt   <= '0;
                        end
                        default: ;
                    endcase
                end
                ST_MUL: if (!bus.flush) begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) {r_hi, r_lo} <= w_prod_fix;
                end
                ST_DIV: if (!bus.flush) begin
                    r_acc <= {w_div_rem, w_quo};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall = w_stall;
    assign bus.done  = w_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a result scoreboard; honours MULDIV_FAST_MULT_EN.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if #(.WIDTH(32)) ifc();
    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rstn(rstn), .bus(ifc.slave));

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_STALL = 0;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op    = o;
        ifc.src_a = a;
        ifc.src_b = b;
    endtask

    // Starts sampling in the cycle the op is presented; returns in the done cycle.
    task automatic wait_done(input string tag, input int exp_stall, input bit drop_start);
        int n = 0;
        bit got = 1'b0;
        logic [63:0] exp;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (ifc.stall) n++;
            if (ifc.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            if (drop_start) ifc.start = 1'b0;
        end
        chk({tag, "_done"}, 64'(got), 64'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        if (got) chk({tag, "_result"}, {ifc.hi, ifc.lo}, exp);
        chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    endtask

    task automatic run(input string tag, input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int exp_stall);
        sb.push_back(exp);
        issue(o, a, b);
        wait_done(tag, exp_stall, 1'b1);
        @(negedge clk);
        #1;
        chk({tag, "_one_pulse"}, 64'(ifc.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        ifc.start = 1'b0;
        ifc.flush = 1'b0;
        ifc.op    = MD_MULT;
        ifc.src_a = '0;
        ifc.src_b = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_hi", 64'(ifc.hi), 64'd0);
        chk("reset_lo", 64'(ifc.lo), 64'd0);
        chk("reset_stall", 64'(ifc.stall), 64'd0);
        chk("reset_done", 64'(ifc.done), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        run("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_STALL);
        run("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, MUL_STALL);
        run("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_STALL);
        run("divu",      MD_DIVU,  32'd100,       32'd7,         {32'd2, 32'd14}, DIV_STALL);
        run("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_STALL);
        run("divu_zero", MD_DIVU,  32'h0000_1234, 32'd0,         {32'h0000_1234, 32'hFFFF_FFFF}, DIV_STALL);
        run("div_zero",  MD_DIV,   32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}, DIV_STALL);

        // Flush mid-divide: HI/LO keep the div_zero result.
        issue(MD_DIV, 32'd100, 32'd3);
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("flush_busy", 64'(ifc.stall), 64'd1);
        ifc.flush = 1'b1;
        #1;
        chk("flush_stall_drop", 64'(ifc.stall), 64'd0);
        @(negedge clk);
        ifc.flush = 1'b0;
        #1;
        chk("flush_idle_stall", 64'(ifc.stall), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            if (ifc.done) saw_done = 1'b1;
            @(negedge clk);
            #1;
        end
        chk("flush_no_done", 64'(saw_done), 64'd0);
        chk("flush_hilo", {ifc.hi, ifc.lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

        // Reset in the middle of a multiply.
        issue(MD_MULT, 32'd7, 32'd9);
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_hi", 64'(ifc.hi), 64'd0);
        chk("rst_mid_lo", 64'(ifc.lo), 64'd0);
        chk("rst_mid_stall", 64'(ifc.stall), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0);
        #1;
        chk("mthi_stall", 64'(ifc.stall), 64'd0);
        @(negedge clk);
        ifc.start = 1'b0;
        #1;
        chk("mthi_hi", 64'(ifc.hi), 64'hA5A5_A5A5);
        chk("mthi_lo", 64'(ifc.lo), 64'd0);
        chk("mthi_done", 64'(ifc.done), 64'd0);

        issue(MD_MTLO, 32'h55, 32'd0);
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.flush = 1'b0;
        #1;
        chk("mtlo_flushed", {ifc.hi, ifc.lo}, {32'hA5A5_A5A5, 32'd0});

        issue(MD_MTLO, 32'h77, 32'd0);
        @(negedge clk);
        ifc.start = 1'b0;
        #1;
        chk("mtlo", {ifc.hi, ifc.lo}, {32'hA5A5_A5A5, 32'h77});

        // Back-to-back: start stays high through DONE, next op taken in the following IDLE cycle.
        sb.push_back({32'd1, 32'd333});
        issue(MD_DIVU, 32'd1000, 32'd3);
        wait_done("b2b_divu", DIV_STALL, 1'b0);
        sb.push_back({32'd1, 32'd0});
        ifc.op    = MD_MULTU;
        ifc.src_a = 32'h0001_0000;
        ifc.src_b = 32'h0001_0000;
        @(negedge clk);
        wait_done("b2b_multu", MUL_STALL, 1'b1);
        @(negedge clk);
        #1;
        chk("b2b_one_pulse", 64'(ifc.done), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
